// File: rtl/apb_cmd_arbiter_if.sv
// Command/response bundle between the requesters, the arbiter and the APB master.
// slave is the arbiter's view; master is the view of everything around it.
interface apb_cmd_arbiter_if #(
  parameter int NR = 4,
  parameter int DW = 32,
  parameter int AW = 8
);
  localparam int SW = DW / 8;
  localparam int CW = 1 + SW + DW + AW;
  localparam int RW = 1 + DW;

  logic [NR*CW-1:0] i_req_cmd;
  logic [NR-1:0]    i_req_valid;
  logic [NR-1:0]    o_req_ready;
  logic [RW-1:0]    o_req_resp;
  logic [CW-1:0]    o_cmd;
  logic             o_valid;
  logic [RW-1:0]    i_resp;
  logic             i_ready;
  logic [NR-1:0]    o_grant;
  logic             o_busy;

  modport slave (
    input  i_req_cmd, i_req_valid, i_resp, i_ready,
    output o_req_ready, o_req_resp, o_cmd, o_valid, o_grant, o_busy
  );

  modport master (
    output i_req_cmd, i_req_valid, i_resp, i_ready,
    input  o_req_ready, o_req_resp, o_cmd, o_valid, o_grant, o_busy
  );
endinterface

// File: rtl/apb_cmd_arbiter.sv
// Round-robin arbiter sharing one APB master command port among NR requesters.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   ARB   | no grant held; pick next valid requester from rr pointer
//   LOCK  | grant held on r_g; command muxed out until i_ready
//
// Every grant is followed by one ARB cycle, so a requester's completing
// valid/ready cycle can never be re-sampled as a fresh request.
module apb_cmd_arbiter #(
  parameter int NR = 4,
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic              pclk,
  input  logic              preset,
  apb_cmd_arbiter_if.slave  bus
);
  localparam int SW = DW / 8;
  localparam int CW = 1 + SW + DW + AW;
  localparam int RW = 1 + DW;
  localparam int PW = (NR > 1) ? $clog2(NR) : 1;

  localparam logic [0:0] S_ARB  = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]    r_state;
  logic [PW-1:0] r_g;
  logic [PW-1:0] r_ptr;
  logic [NR-1:0] r_grant;

  logic          w_found;
  logic [PW-1:0] w_sel;
  logic [NR-1:0] w_sel_oh;
  logic [PW-1:0] w_ptr_nxt;
  logic [NR-1:0] w_ready;
  logic [CW-1:0] w_cmd;

  // Round-robin search: first valid requester starting at r_ptr, wrapping.
  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_sel   = '0;
    v_idx   = 0;
    for (int i = 0; i < NR; i++) begin
      v_idx = (int'(r_ptr) + i) % NR;
      if (!w_found && bus.i_req_valid[v_idx]) begin
        w_found = 1'b1;
        w_sel   = PW'(v_idx);
      end
    end
  end

  assign w_sel_oh  = NR'(1) << w_sel;
  assign w_ptr_nxt = (int'(r_g) == NR - 1) ? '0 : r_g + PW'(1);

  // Grant FSM; reset abandons any transfer in flight.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= S_ARB;
      r_g     <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        S_ARB: begin
          if (w_found) begin
            r_state <= S_LOCK;
            r_g     <= w_sel;
            r_grant <= w_sel_oh;
          end
        end
        S_LOCK: begin
          if (bus.i_ready) begin
            r_state <= S_ARB;
            r_ptr   <= w_ptr_nxt;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= S_ARB;
          r_grant <= '0;
        end
      endcase
    end
  end

  // Ready and command are only routed while a grant is held.
  always_comb begin
    w_ready = '0;
    w_cmd   = '0;
    if (r_state == S_LOCK) begin
      w_ready = r_grant & {NR{bus.i_ready}};
      w_cmd   = bus.i_req_cmd[int'(r_g)*CW +: CW];
    end
  end

  assign bus.o_req_ready = w_ready;
  assign bus.o_req_resp  = bus.i_resp;
  assign bus.o_cmd       = w_cmd;
  assign bus.o_valid     = (r_state == S_LOCK);
  assign bus.o_busy      = (r_state == S_LOCK);
  assign bus.o_grant     = r_grant;

  a_grant_onehot: assert property (@(posedge pclk) disable iff (preset)
    $onehot0(bus.o_grant));
  a_ready_subset: assert property (@(posedge pclk) disable iff (preset)
    (bus.o_req_ready & ~bus.o_grant) == '0);
  a_valid_state: assert property (@(posedge pclk) disable iff (preset)
    bus.o_valid == (r_state == S_LOCK));
endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Directed bench for apb_cmd_arbiter with NR=4, DW=32, AW=8.
module tb_apb_cmd_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = DW / 8;
  localparam int CW = 1 + SW + DW + AW;
  localparam int RW = 1 + DW;

  logic pclk;
  logic preset;
  int   n_tests;
  int   n_fail;
  int   gap;
  logic [CW-1:0] cmds [NR];

  apb_cmd_arbiter_if #(.NR(NR), .DW(DW), .AW(AW)) bus ();

  apb_cmd_arbiter #(.NR(NR), .DW(DW), .AW(AW)) u_dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    preset          = 1'b1;
    bus.i_req_valid = '0;
    bus.i_ready     = 1'b0;
    bus.i_resp      = '0;
    cyc();
    cyc();
    preset = 1'b0;
  endtask

  // Entered just after the edge that moved the arbiter into LOCK on requester k.
  // Ends in the ARB bubble cycle with i_req_valid = valid_after.
  task automatic xfer(input int k, input int waits, input logic [RW-1:0] resp,
                      input logic [NR-1:0] valid_after);
    logic [NR-1:0] oh;
    oh = NR'(1) << k;
    chk("lock_grant", 64'(bus.o_grant), 64'(oh));
    chk("lock_valid", 64'(bus.o_valid), 64'd1);
    chk("lock_busy",  64'(bus.o_busy),  64'd1);
    chk("lock_cmd",   64'(bus.o_cmd),   64'(cmds[k]));
    for (int w = 0; w < waits; w++) begin
      chk("wait_ready", 64'(bus.o_req_ready), 64'd0);
      chk("wait_grant", 64'(bus.o_grant), 64'(oh));
      cyc();
    end
    bus.i_ready = 1'b1;
    bus.i_resp  = resp;
    #1;
    chk("done_ready", 64'(bus.o_req_ready), 64'(oh));
    chk("done_resp",  64'(bus.o_req_resp),  64'(resp));
    cyc();
    bus.i_ready     = 1'b0;
    bus.i_req_valid = valid_after;
    #1;
    chk("bubble_valid", 64'(bus.o_valid), 64'd0);
    chk("bubble_grant", 64'(bus.o_grant), 64'd0);
    chk("bubble_busy",  64'(bus.o_busy),  64'd0);
    chk("bubble_cmd",   64'(bus.o_cmd),   64'd0);
    bus.i_ready = 1'b1;
    #1;
    chk("arb_ready_ignored", 64'(bus.o_req_ready), 64'd0);
    bus.i_ready = 1'b0;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cmds[0] = {1'b0, 4'h0, 32'h0000_0000, 8'h40};
    cmds[1] = {1'b1, 4'h3, 32'h1111_2222, 8'h24};
    cmds[2] = {1'b1, 4'hF, 32'hDEAD_BEEF, 8'h10};
    cmds[3] = {1'b1, 4'hC, 32'h3333_4444, 8'hFC};
    for (int k = 0; k < NR; k++) bus.i_req_cmd[k*CW +: CW] = cmds[k];

    // Reset state
    do_reset();
    chk("rst_grant", 64'(bus.o_grant),     64'd0);
    chk("rst_valid", 64'(bus.o_valid),     64'd0);
    chk("rst_busy",  64'(bus.o_busy),      64'd0);
    chk("rst_ready", 64'(bus.o_req_ready), 64'd0);
    chk("rst_cmd",   64'(bus.o_cmd),       64'd0);

    // Single request on requester 2, one wait state; then wrap contention 3 -> 1
    bus.i_req_valid = 4'b0100;
    #1;
    chk("t1_arb_valid", 64'(bus.o_valid), 64'd0);
    cyc();
    xfer(2, 1, {1'b0, 32'h1234_5678}, 4'b1010);
    cyc();
    xfer(3, 0, {1'b0, 32'h0000_0003}, 4'b0010);
    cyc();
    xfer(1, 2, {1'b0, 32'h0000_0001}, 4'b1111);
    cyc();
    xfer(2, 0, {1'b0, 32'h0000_0002}, 4'b0000);

    // All four valid from reset: order 0,1,2,3
    do_reset();
    bus.i_req_valid = 4'b1111;
    cyc();
    xfer(0, 0, {1'b0, 32'hA0A0_0000}, 4'b1110);
    cyc();
    xfer(1, 1, {1'b0, 32'hA0A0_0001}, 4'b1100);
    cyc();
    xfer(2, 0, {1'b0, 32'hA0A0_0002}, 4'b1000);
    cyc();
    xfer(3, 2, {1'b0, 32'hA0A0_0003}, 4'b0000);

    // Error response on a read by requester 0
    do_reset();
    bus.i_req_valid = 4'b0001;
    cyc();
    xfer(0, 0, {1'b1, 32'h0000_0BAD}, 4'b0000);

    // Reset mid-transfer: pointer was 2, must restart at 0
    do_reset();
    bus.i_req_valid = 4'b0010;
    cyc();
    xfer(1, 0, {1'b0, 32'h0}, 4'b0100);
    cyc();
    chk("mid_lock_grant", 64'(bus.o_grant), 64'h4);
    preset          = 1'b1;
    bus.i_req_valid = 4'b1010;
    cyc();
    chk("mid_rst_valid", 64'(bus.o_valid),     64'd0);
    chk("mid_rst_grant", 64'(bus.o_grant),     64'd0);
    chk("mid_rst_busy",  64'(bus.o_busy),      64'd0);
    chk("mid_rst_ready", 64'(bus.o_req_ready), 64'd0);
    preset = 1'b0;
    cyc();
    xfer(1, 0, {1'b0, 32'h0}, 4'b0000);

    // Starvation bound: everyone valid continuously
    do_reset();
    bus.i_req_valid = 4'b1111;
    gap = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (bus.o_grant[0]) gap = 0;
      else gap++;
      chk("starve_gap", 64'(gap <= 3), 64'd1);
      xfer(i % 4, i % 2, {1'b0, 32'(i)}, 4'b1111);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_cmd_arbiter.md
Name: apb_cmd_arbiter

Overview:
- Shares one APB master command port among NR requesters, each with its own valid-ready command interface.
- Uses round-robin arbitration. The grant is registered and held until the downstream transfer completes.
- Routes the response and ready back to the granted requester only.
- Sits between system command sources (CPU bridge, DMA, debug) and the apb_master command/response interface.

Parameters:
- NR, 4: number of requesters; 1 to 16 inclusive.
- DW, 32: APB data width.
- AW, 8: APB address width; 32 maximum.
- SW (derived), DW/8: strobe width.
- CW (derived), 1+SW+DW+AW: command width, packed {pwrite, pstrb, pwdata, paddr}.
- RW (derived), 1+DW: response width, packed {pslverr, prdata}.
- PW (derived), max(1, clog2(NR)): width of the pointer and index.

Ports:
- pclk  in  1  clock.
- preset  in  1  reset. One clock, pclk. Reset preset is synchronous and active-high.
- i_req_cmd  in  NR*CW  requester commands; requester k occupies bits [k*CW +: CW].
- i_req_valid  in  NR  per-requester command valid.
- o_req_ready  out  NR  per-requester ready; one-hot or zero.
- o_req_resp  out  RW  response; broadcast to all requesters, qualified by o_req_ready.
- o_cmd  out  CW  command to the APB master.
- o_valid  out  1  command valid to the APB master.
- i_resp  in  RW  response from the APB master.
- i_ready  in  1  ready from the APB master; transfer done.
- o_grant  out  NR  registered one-hot grant; zero when idle.
- o_busy  out  1  high while a grant is held.

Behaviour:
- State machine, two states:
  - ARB: no grant held.
  - LOCK: grant held on requester g (PW-bit register).
- Reset (preset=1 at a pclk edge):
  - state=ARB, g=0, rr_ptr=0.
  - o_grant=0, o_valid=0, o_busy=0, o_req_ready=0.
  - o_cmd and o_req_resp are don't-care while invalid. Implementation drives o_cmd=0 in ARB.
  - Reset mid-LOCK abandons the transfer immediately. The APB side is reset by the same system reset.
- ARB:
  - If any i_req_valid is set, select the first k with i_req_valid[k]=1, searching rr_ptr, rr_ptr+1, ..., modulo NR.
  - Next cycle: state=LOCK, g=k, o_grant=onehot(k).
  - If no i_req_valid is set, stay in ARB.
- LOCK:
  - o_valid=1 and o_busy=1.
  - o_cmd = i_req_cmd[g*CW +: CW]; combinational mux on the registered g.
  - o_req_resp = i_resp.
  - o_req_ready[g] = i_ready (combinational). All other o_req_ready bits are 0.
  - When i_ready=1: the next state is ARB, rr_ptr <= (g+1) mod NR, and o_grant clears.
  - o_valid is set by state, not by i_req_valid[g]. If a requester drops valid while in LOCK, that is a requester protocol violation; the arbiter holds the grant until i_ready.
- Latency:
  - i_req_valid rising in ARB gives o_valid=1 on the next cycle.
  - The downstream APB transfer is a minimum of 2 cycles (apb_master IDLE then ACCESS).
  - The arbiter inserts exactly one ARB bubble cycle between consecutive grants. This keeps a requester's same-cycle valid/ready from being re-sampled as a new request.
- Fairness: no requester waits more than NR-1 other transfers after asserting valid.
- Boundary conditions:
  - NR=1: rr_ptr stays 0 and g stays 0; behaves as a registered pass-through with a 1-cycle bubble.
  - Pointer wrap: g=NR-1 on completion gives rr_ptr=0.
  - Multiple requesters valid simultaneously: choose per pointer order only; no fixed priority.
  - i_ready=1 while in ARB: ignored; no o_req_ready is asserted.
  - i_ready held high continuously: each grant completes in its first LOCK cycle.
- Assertions:
  - o_grant is one-hot or zero.
  - o_req_ready is a subset of o_grant.
  - o_valid equals (state==LOCK).

Test Plan:
- Single request: NR=4. Req2 asserts valid with cmd {pwrite=1, pstrb=F, pwdata=DEADBEEF, paddr=0x10}. Expect o_valid on the next cycle with o_cmd matching. The APB slave readies after 1 wait state. Expect o_req_ready[2] for exactly 1 cycle, with o_req_resp = {0, prdata}. Then rr_ptr=3.
- All four valid from reset, with each requester dropping valid after its ready: grant order 0,1,2,3. Each grant is separated by one ARB cycle. o_grant is never multi-hot.
- Contention with wrap: rr_ptr=3, requesters 1 and 3 valid. Grant 3 then 1, and rr_ptr ends at 2.
- Error response: slave returns pslverr=1, prdata=0x0BAD on a read by requester 0. o_req_resp=0x1_00000BAD when o_req_ready[0]=1. Requesters 1 to 3 see no ready.
- Reset mid-transfer: assert preset during LOCK with the slave not ready. The next cycle has o_valid=0, o_grant=0, rr_ptr=0. After reset deasserts with requester 1 valid, requester 1 is granted.
- Starvation bound: requester 0 keeps valid asserted continuously while requesters 1 to 3 issue back-to-back. Requester 0 is granted at least once every 4 grants, and no o_req_ready fires while in ARB.
